// File: rtl/coin_return_unit_pkg.sv
// rtl/coin_return_unit_pkg.sv - shared constants, state encoding and price/value tables
package coin_return_unit_pkg;

  localparam int kNumCoins  = 3;
  localparam int kNumItems  = 4;
  localparam int kTotalBits = 31;

  typedef enum logic {
    IDLE   = 1'b0,
    RETURN = 1'b1
  } state_t;

  // Coin k face value: 100, 500, 1000.
  function automatic int unsigned coin_value(input int k);
    case (k)
      0:       return 100;
      1:       return 500;
      default: return 1000;
    endcase
  endfunction

  // Item i price: 400, 500, 1000, 2000.
  function automatic int unsigned item_price(input int i);
    case (i)
      0:       return 400;
      1:       return 500;
      2:       return 1000;
      default: return 2000;
    endcase
  endfunction

endpackage

// File: rtl/coin_return_unit_if.sv
// rtl/coin_return_unit_if.sv - vending credit/return bus between controller and credit stage
interface coin_return_unit_if
  import coin_return_unit_pkg::*;
#(
  parameter int NUM_COINS  = kNumCoins,
  parameter int NUM_ITEMS  = kNumItems,
  parameter int TOTAL_BITS = kTotalBits
);

  logic [NUM_COINS-1:0]  i_input_coin;
  logic [NUM_ITEMS-1:0]  i_select_item;
  logic                  return_flag;
  logic [NUM_ITEMS-1:0]  o_available_item;
  logic [NUM_ITEMS-1:0]  o_output_item;
  logic [NUM_COINS-1:0]  o_return_coin;
  logic                  o_return_done;
  logic                  o_busy;
  logic [TOTAL_BITS-1:0] o_current_total;

  modport master (
    output i_input_coin, i_select_item, return_flag,
    input  o_available_item, o_output_item, o_return_coin,
           o_return_done, o_busy, o_current_total
  );

  modport slave (
    input  i_input_coin, i_select_item, return_flag,
    output o_available_item, o_output_item, o_return_coin,
           o_return_done, o_busy, o_current_total
  );

endinterface

// File: rtl/coin_return_unit_greedy_coin_select.sv
// rtl/coin_return_unit_greedy_coin_select.sv - picks the largest coin not exceeding the balance
module greedy_coin_select
  import coin_return_unit_pkg::*;
#(
  parameter int TOTAL_BITS = kTotalBits
) (
  input  logic [TOTAL_BITS-1:0] balance,
  output logic [kNumCoins-1:0]  coin_onehot,
  output logic [TOTAL_BITS-1:0] coin_val
);

  // Scan upward so the largest fitting denomination overwrites smaller ones.
  always_comb begin
    coin_onehot = '0;
    coin_val    = '0;
    for (int k = 0; k < kNumCoins; k++) begin
      if (balance >= TOTAL_BITS'(coin_value(k))) begin
        coin_onehot    = '0;
        coin_onehot[k] = 1'b1;
        coin_val       = TOTAL_BITS'(coin_value(k));
      end
    end
  end

endmodule

// File: rtl/coin_return_unit.sv
// rtl/coin_return_unit.sv - credit accumulation, item dispensing and greedy change return
module coin_return_unit
  import coin_return_unit_pkg::*;
#(
  parameter int TOTAL_BITS = kTotalBits,
  parameter int NUM_COINS  = kNumCoins,
  parameter int NUM_ITEMS  = kNumItems
) (
  input  logic         clk,
  input  logic         reset,
  coin_return_unit_if.slave bus
);

  localparam int SUM_BITS = TOTAL_BITS + 1;

  state_t                state_q, state_d;
  logic [TOTAL_BITS-1:0] balance_q, balance_d;
  logic [NUM_ITEMS-1:0]  item_q, item_d;
  logic [NUM_COINS-1:0]  coin_q, coin_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic [SUM_BITS-1:0]   coin_sum;
  logic [SUM_BITS-1:0]   sum_ext;
  logic [TOTAL_BITS-1:0] eff_balance;
  logic                  sel_valid;
  logic [TOTAL_BITS-1:0] sel_price;
  logic [NUM_ITEMS-1:0]  sel_onehot;
  logic [NUM_COINS-1:0]  g_onehot;
  logic [TOTAL_BITS-1:0] g_value;
  logic [TOTAL_BITS-1:0] g_remain;

  greedy_coin_select #(.TOTAL_BITS(TOTAL_BITS)) u_greedy (
    .balance     (balance_q),
    .coin_onehot (g_onehot),
    .coin_val    (g_value)
  );

  assign g_remain = balance_q - g_value;

  // Credit after this cycle's coins (dropped on overflow) and the lowest-index requested item.
  always_comb begin
    coin_sum = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (bus.i_input_coin[k]) coin_sum = coin_sum + SUM_BITS'(coin_value(k));
    end
    sum_ext     = {1'b0, balance_q} + coin_sum;
    eff_balance = sum_ext[TOTAL_BITS] ? balance_q : sum_ext[TOTAL_BITS-1:0];
    sel_valid   = 1'b0;
    sel_price   = '0;
    sel_onehot  = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (bus.i_select_item[i]) begin
        sel_valid     = 1'b1;
        sel_price     = TOTAL_BITS'(item_price(i));
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Next state, next balance and next registered pulses.
  always_comb begin
    state_d   = state_q;
    balance_d = balance_q;
    item_d    = '0;
    coin_d    = '0;
    done_d    = 1'b0;
    busy_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.return_flag) begin
          if (balance_q != '0) begin
            coin_d    = g_onehot;
            balance_d = g_remain;
            if (g_remain == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = RETURN;
              busy_d  = 1'b1;
            end
          end
        end else if (sel_valid && (sel_price <= eff_balance)) begin
          item_d    = sel_onehot;
          balance_d = eff_balance - sel_price;
        end else begin
          balance_d = eff_balance;
        end
      end
      RETURN: begin
        coin_d    = g_onehot;
        balance_d = g_remain;
        if (g_remain == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, balance and output pulse registers; reset abandons any pending return.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      balance_q <= '0;
      item_q    <= '0;
      coin_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      balance_q <= balance_d;
      item_q    <= item_d;
      coin_q    <= coin_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Items are only offered while idle and affordable from the registered balance.
  always_comb begin
    bus.o_available_item = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      bus.o_available_item[i] = (state_q == IDLE) && (TOTAL_BITS'(item_price(i)) <= balance_q);
    end
  end

  assign bus.o_output_item   = item_q;
  assign bus.o_return_coin   = coin_q;
  assign bus.o_return_done   = done_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_current_total = balance_q;

endmodule

// File: tb/tb_coin_return_unit.sv
// tb/tb_coin_return_unit.sv - scoreboard bench with a queue-based change model
module tb_coin_return_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  coin_return_unit_if bus ();

  coin_return_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0] item;
    logic [2:0] coin;
    bit         done;
    bit         busy;
    longint     total;
    logic [3:0] avail;
  } exp_t;

  exp_t   sb_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  longint m_bal = 0;
  int     m_pend[$];

  function automatic longint coin_val(input int k);
    return (k == 0) ? 100 : (k == 1) ? 500 : 1000;
  endfunction

  function automatic longint price(input int i);
    return (i == 0) ? 400 : (i == 1) ? 500 : (i == 2) ? 1000 : 2000;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, advance the model, queue what the DUT must show after the edge.
  task automatic step(input logic [2:0] coin, input logic [3:0] sel, input bit rf, input bit rst);
    exp_t e;
    longint cs;
    longint r;
    int idx;
    @(negedge clk);
    bus.i_input_coin  = coin;
    bus.i_select_item = sel;
    bus.return_flag   = rf;
    reset             = rst;
    e.item = '0; e.coin = '0; e.done = 0; e.busy = 0;
    if (rst) begin
      m_bal = 0;
      m_pend.delete();
    end else if (m_pend.size() > 0 || (rf && m_bal > 0)) begin
      if (m_pend.size() == 0) begin
        r = m_bal;
        while (r >= 1000) begin m_pend.push_back(2); r -= 1000; end
        while (r >= 500)  begin m_pend.push_back(1); r -= 500;  end
        while (r >= 100)  begin m_pend.push_back(0); r -= 100;  end
      end
      idx = m_pend.pop_front();
      e.coin[idx] = 1'b1;
      m_bal -= coin_val(idx);
      e.done = (m_pend.size() == 0);
      e.busy = (m_pend.size() > 0);
    end else if (!rf) begin
      cs = 0;
      for (int k = 0; k < 3; k++) if (coin[k]) cs += coin_val(k);
      if (m_bal + cs > 64'd2147483647) cs = 0;
      m_bal += cs;
      idx = -1;
      for (int i = 3; i >= 0; i--) if (sel[i]) idx = i;
      if (idx >= 0 && price(idx) <= m_bal) begin
        e.item[idx] = 1'b1;
        m_bal -= price(idx);
      end
    end
    e.total = m_bal;
    for (int i = 0; i < 4; i++) e.avail[i] = (m_pend.size() == 0) && (price(i) <= m_bal);
    sb_q.push_back(e);
  endtask

  // Monitor: after every edge, compare the DUT against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("output_item", bus.o_output_item, e.item);
        chk("return_coin", bus.o_return_coin, e.coin);
        chk("return_done", bus.o_return_done, e.done);
        chk("busy",        bus.o_busy,        e.busy);
        chk("total",       bus.o_current_total, e.total);
        chk("available",   bus.o_available_item, e.avail);
      end
    end
  end

  initial begin
    bus.i_input_coin  = '0;
    bus.i_select_item = '0;
    bus.return_flag   = 1'b0;
    step(3'b000, 4'b0000, 0, 1);
    step(3'b000, 4'b0000, 0, 1);
    // Insert 1000 then 500, buy item 2, then an unaffordable item 3.
    step(3'b100, 4'b0000, 0, 0);
    step(3'b010, 4'b0000, 0, 0);
    step(3'b000, 4'b0100, 0, 0);
    step(3'b000, 4'b1000, 0, 0);
    // Reach 1600 and drain it.
    step(3'b100, 4'b0000, 0, 0);
    step(3'b001, 4'b0000, 0, 0);
    repeat (3) step(3'b000, 4'b0000, 1, 0);
    step(3'b000, 4'b0000, 0, 0);
    // Return request with nothing to return.
    repeat (5) step(3'b000, 4'b0000, 1, 0);
    // 2600 with a coin inserted mid-return.
    step(3'b100, 4'b0000, 0, 0);
    step(3'b100, 4'b0000, 0, 0);
    step(3'b011, 4'b0000, 0, 0);
    step(3'b000, 4'b0000, 1, 0);
    step(3'b010, 4'b0001, 0, 0);
    step(3'b010, 4'b0000, 1, 0);
    step(3'b000, 4'b0000, 0, 0);
    step(3'b000, 4'b0000, 0, 0);
    // 1500 with reset after the first returned coin.
    step(3'b110, 4'b0000, 0, 0);
    step(3'b000, 4'b0000, 1, 0);
    step(3'b000, 4'b0000, 0, 1);
    repeat (3) step(3'b000, 4'b0000, 0, 0);
    // Multiple select bits: lowest index wins.
    step(3'b110, 4'b1110, 0, 0);
    step(3'b000, 4'b1111, 0, 0);
    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [2:0] c;
      logic [3:0] s;
      bit rf, rs;
      c  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      s  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rf = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 99) == 0);
      step(c, s, rf, rs);
    end
    step(3'b000, 4'b0000, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coin_return_unit.md
Name: coin_return_unit

Overview:
- Credit-holding and change-dispensing stage downstream of the timeout checker in the vending machine.
- Accumulates inserted coins, deducts prices of dispensed items, and publishes per-item availability.
- When the timeout checker raises return_flag, drains the remaining balance as a coin stream, one coin per cycle, largest denomination first.

Parameters:
- TOTAL_BITS, 31, width of the balance register (matches kTotalBits).
- NUM_COINS, 3, number of coin denominations (matches kNumCoins).
- NUM_ITEMS, 4, number of items (matches kNumItems).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_input_coin  in  NUM_COINS  one-cycle pulse per inserted coin; bit k = coin k (100, 500, 1000).
- i_select_item  in  NUM_ITEMS  one-cycle item request; bit i = item i (400, 500, 1000, 2000).
- return_flag  in  1  level from the timeout checker; 1 = time expired, return change.
- o_available_item  out  NUM_ITEMS  combinational; bit i = (price_i <= balance) and state==IDLE.
- o_output_item  out  NUM_ITEMS  registered one-hot pulse; item dispensed.
- o_return_coin  out  NUM_COINS  registered one-hot pulse; coin returned this cycle.
- o_return_done  out  1  registered pulse, coincident with the last returned coin.
- o_busy  out  1  registered; 1 while in RETURN.
- o_current_total  out  TOTAL_BITS  registered balance.

Behaviour:
- Reset (synchronous, sampled at the edge): balance=0, state=IDLE, all registered outputs 0. Reset mid-RETURN abandons the remaining balance with no further coins.
- States: IDLE and RETURN.
- IDLE, return_flag=0:
  - balance_next = balance + sum(values of set coin bits) − accepted price.
  - Item acceptance uses the pre-edge balance plus this cycle's coins.
  - If several select bits are set, only the lowest-index requested item is considered.
  - An accepted item produces an o_output_item pulse for exactly one cycle after the edge.
  - A request with insufficient funds is dropped silently; balance is unchanged apart from the coins.
- IDLE, return_flag=1, balance>0:
  - Return has priority; this cycle's coin and select inputs are ignored.
  - At the same edge: emit greedy coin g = largest value <= balance, balance -= g.
  - If the new balance is 0: o_return_done=1 and stay IDLE; otherwise go to RETURN and set o_busy=1.
- IDLE, return_flag=1, balance==0: no action, no o_return_done.
- RETURN:
  - Every edge: emit greedy coin, subtract its value.
  - On reaching 0: o_return_done=1 with that coin, go to IDLE, clear o_busy.
  - i_input_coin, i_select_item and return_flag are ignored; no accumulation.
  - o_available_item is all-zero.
- Latency: first coin is visible one cycle after the edge that samples return_flag. A balance B drains in (number of greedy coins of B) consecutive cycles with no gaps.
- Balance is always a multiple of 100, so the greedy drain terminates.
- Overflow: if the coin addition would exceed 2^TOTAL_BITS−1, all coins that cycle are ignored and item acceptance proceeds on the old balance.
- o_return_coin and o_output_item are all-zero in every cycle without an event.

Decomposition:
- Shared package/define file (vending_machine_def) holds:
  - kNumCoins, kNumItems, kTotalBits.
  - coin values 100/500/1000 and item prices 400/500/1000/2000.
  - state encodings IDLE=0, RETURN=1.
- One combinational sub-module, greedy_coin_select: input balance; outputs one-hot coin and coin value (zero when balance < 100).
- FSM and balance register stay in the top.

Test Plan:
- Insert 1000, then 500, on separate cycles -> o_current_total 1000 then 1500; o_available_item 4'b0111 after the second coin.
- Balance 1500, select 4'b0100 (1000) -> o_output_item 4'b0100 one cycle, balance 500; then select 4'b1000 -> no output, balance stays 500.
- Balance 1600, return_flag=1 -> o_return_coin 100(1000), 010(500), 001(100) on 3 consecutive cycles; o_return_done with the third; o_busy high for 2 cycles; balance 0.
- Balance 0, return_flag=1 for 5 cycles -> no coins, no done, o_busy 0.
- Balance 2600 mid-RETURN after first coin, insert coin 500 -> coin ignored; remaining coins 1000, 500, 100 returned; final balance 0.
- Balance 1500, reset asserted after first returned coin -> next cycle all outputs 0, balance 0, state IDLE, no further coins.
